// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall counter built when PIPE_STALL_CNT_EN is defined; otherwise stall_cnt is tied to zero.
module pipe_stage_buf #(
  parameter int              DATA_W      = 160,
  parameter int              CTRL_W      = 10,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (out_fire) begin
          state_d     = EMPTY;
          main_ctrl_d = BUBBLE_CTRL;
        end else if (in_fire) begin
          state_d     = TWO;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything, including a beat accepted this same cycle.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 16'h0000;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
